// File: rtl/uart_rx.sv
// uart_rx: 8N1-style asynchronous serial receiver, LSB first, with 16x oversampling.
//
// The serial line is synchronized, the start bit is validated at its midpoint,
// and each data bit is sampled at its midpoint. A completed frame is delivered
// as a one-cycle rx_done_tick, with dout, frame_err and parity_err.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : a parity bit follows the data bits; parity_err reports a mismatch
//   undefined : no parity bit; parity_err is tied to 0
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   s_tick       single-cycle strobe at 16x baud
//   rx           raw serial line, idle high, asynchronous to clk
//   dout         last received byte, LSB-aligned, upper bits zero when DBIT < 8
//   rx_done_tick one-cycle pulse when a frame completes
//   frame_err    stop bit of the last completed frame was sampled low
//   parity_err   parity mismatch on the last completed frame
module uart_rx #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned S_W = 5;
    localparam int unsigned N_W = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [S_W-1:0]  s_reg, s_next;
    logic [N_W-1:0]  n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [7:0]      dout_reg, dout_next;
    logic            done_reg, done_next;
    logic            ferr_reg, ferr_next;
    logic            rx_meta, rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic p_reg, p_next;
    logic perr_reg, perr_next;
`endif

    // State, counters, shift register and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_reg     <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            p_reg     <= p_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    // Next-state and completion logic
    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        ferr_next  = ferr_reg;
`ifdef UART_RX_PARITY_EN
        p_next     = p_reg;
        perr_next  = perr_reg;
`endif
        case (state_reg)
            // Leave IDLE on the falling edge alone; s_tick is not needed here
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            // Re-check the line at the middle of the start bit to reject glitches
            START: begin
                if (s_tick) begin
                    if (s_reg == S_W'(7)) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            // Sample each data bit one bit-time after the previous midpoint
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + N_W'(1);
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            // Parity bit uses the same timing as a data bit
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next     = '0;
                        p_next     = rx_s;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`endif
            // Stop bit: publish the frame; a low stop bit only flags, never stalls
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_W'(SB_TICK - 1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        dout_next  = 8'(b_reg);
                        ferr_next  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_next  = (^b_reg) ^ p_reg ^ 1'(PARITY_ODD);
`endif
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign dout         = dout_reg;
    assign rx_done_tick = done_reg;
    assign frame_err    = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_reg;
`else
    // No parity bit in the frame; PARITY_ODD is a don't-care
    assign parity_err   = 1'b0 & 1'(PARITY_ODD);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (16 ticks per bit, s_tick every 4 clk).
module tb_uart_rx;

    logic       clk;
    logic       reset_n;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int n_cmp;
    int n_bad;

    logic [7:0] q_data[$];
    logic       q_ferr[$];
    logic       q_perr[$];

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed frame, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (rx_done_tick === 1'b1) begin
            q_data.push_back(dout);
            q_ferr.push_back(frame_err);
            q_perr.push_back(parity_err);
        end
    end

    task automatic clear_q();
        q_data.delete();
        q_ferr.delete();
        q_perr.delete();
    endtask

    // One s_tick pulse; returns at the negedge right after the edge that saw it
    task automatic tick();
        repeat (3) @(negedge clk);
        s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
    endtask

    task automatic idle_ticks(input int k);
        rx = 1'b1;
        repeat (k) tick();
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (16) tick();
    endtask

    // Start bit, data bits LSB first, and the parity bit when compiled in
    task automatic send_data(input logic [7:0] d, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) rx = 1'b1;
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip);
        send_data(d, par_flip);
        send_bit(1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        s_tick  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h want 00", dout); end
        n_cmp++; if (rx_done_tick !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", rx_done_tick); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %b want 0", frame_err); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL reset_perr got %b want 0", parity_err); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        idle_ticks(4);
        clear_q();
        send_data(8'hA5, 1'b0);
        rx = 1'b1;
        repeat (7) tick();
        n_cmp++; if (q_data.size() != 0) begin n_bad++; $display("FAIL basic_early got %0d pulses want 0", q_data.size()); end
        tick();
        n_cmp++; if (rx_done_tick !== 1'b1) begin n_bad++; $display("FAIL basic_done_timing got %b want 1", rx_done_tick); end
        n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL basic_dout got %h want a5", dout); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL basic_ferr got %b want 0", frame_err); end
        n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL basic_perr got %b want 0", parity_err); end
        @(negedge clk);
        n_cmp++; if (rx_done_tick !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b want 0", rx_done_tick); end
        repeat (8) tick();
        n_cmp++; if (q_data.size() != 1) begin n_bad++; $display("FAIL basic_pulses got %0d want 1", q_data.size()); end
    endtask

    task automatic test_glitch();
        idle_ticks(4);
        clear_q();
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (12) tick();
        n_cmp++; if (q_data.size() != 0) begin n_bad++; $display("FAIL glitch_pulses got %0d want 0", q_data.size()); end
        n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL glitch_dout got %h want a5", dout); end
        // A clean frame right after proves the FSM returned to IDLE
        send_frame(8'h69, 1'b0);
        idle_ticks(4);
        n_cmp++; if (q_data.size() != 1 || dout !== 8'h69) begin n_bad++; $display("FAIL glitch_recover got %0d pulses dout %h want 1 69", q_data.size(), dout); end
    endtask

    task automatic test_frame_err();
        idle_ticks(4);
        clear_q();
        send_data(8'h3C, 1'b0);
        // Low stop bit, released before the re-armed START reaches its midpoint
        rx = 1'b0;
        repeat (10) tick();
        idle_ticks(10);
        n_cmp++; if (q_data.size() != 1) begin n_bad++; $display("FAIL ferr_pulses got %0d want 1", q_data.size()); end
        else begin
            n_cmp++; if (q_data[0] !== 8'h3C) begin n_bad++; $display("FAIL ferr_dout got %h want 3c", q_data[0]); end
            n_cmp++; if (q_ferr[0] !== 1'b1) begin n_bad++; $display("FAIL ferr_flag got %b want 1", q_ferr[0]); end
        end
        send_frame(8'h01, 1'b0);
        idle_ticks(4);
        n_cmp++; if (q_data.size() != 2) begin n_bad++; $display("FAIL ferr_next_pulses got %0d want 2", q_data.size()); end
        else begin
            n_cmp++; if (q_data[1] !== 8'h01) begin n_bad++; $display("FAIL ferr_next_dout got %h want 01", q_data[1]); end
            n_cmp++; if (q_ferr[1] !== 1'b0) begin n_bad++; $display("FAIL ferr_next_flag got %b want 0", q_ferr[1]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h00;
        exp_d[1] = 8'hFF;
        exp_d[2] = 8'h55;
        idle_ticks(4);
        clear_q();
        for (int i = 0; i < 3; i++) send_frame(exp_d[i], 1'b0);
        idle_ticks(4);
        n_cmp++; if (q_data.size() != 3) begin n_bad++; $display("FAIL b2b_pulses got %0d want 3", q_data.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++; if (q_data[i] !== exp_d[i] || q_ferr[i] !== 1'b0) begin
                    n_bad++; $display("FAIL b2b_frame%0d got %h/%b want %h/0", i, q_data[i], q_ferr[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_ticks(4);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL rstmid_dout got %h want 00", dout); end
        n_cmp++; if (rx_done_tick !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_flags got %b%b%b want 000", rx_done_tick, frame_err, parity_err);
        end
        repeat (3) @(negedge clk);
        rx = 1'b1;
        reset_n = 1'b1;
        clear_q();
        idle_ticks(16);
        send_frame(8'h81, 1'b0);
        idle_ticks(4);
        n_cmp++; if (q_data.size() != 1) begin n_bad++; $display("FAIL rstmid_pulses got %0d want 1", q_data.size()); end
        n_cmp++; if (dout !== 8'h81) begin n_bad++; $display("FAIL rstmid_dout_after got %h want 81", dout); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        idle_ticks(4);
        clear_q();
        send_frame(8'h07, 1'b0);
        send_frame(8'h07, 1'b1);
        idle_ticks(4);
        n_cmp++; if (q_data.size() != 2) begin n_bad++; $display("FAIL par_pulses got %0d want 2", q_data.size()); end
        else begin
            n_cmp++; if (q_perr[0] !== 1'b0) begin n_bad++; $display("FAIL par_good got %b want 0", q_perr[0]); end
            n_cmp++; if (q_perr[1] !== 1'b1) begin n_bad++; $display("FAIL par_bad got %b want 1", q_perr[1]); end
        end
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        rx      = 1'b1;
        s_tick  = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
